// File: rtl/calc_port_responder.sv
// Responder end of one calculator request port. Accepts a two-cycle request
// (cmd/op1/tag, then op2), runs add/sub or shift through separate fixed-latency
// pipelines, queues completions and reports one response per cycle.
// Vectors are MSB-first; the external bit 0 is bit 31 (or 3/1) here.
// Optional feature: define CALC_TAG_CHECK_EN to reject commands whose tag is
// still outstanding (tag_err pulse, no response).
module calc_port_responder #(
  parameter int unsigned ADD_LAT    = 1,
  parameter int unsigned SHIFT_LAT  = 3,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req_cmd,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_tag,
  output logic [1:0]  out_resp,
  output logic [31:0] out_data,
  output logic [1:0]  out_tag,
  output logic        busy,
  output logic        tag_err
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CntW-1:0] DepthC = CntW'(FIFO_DEPTH);

  localparam logic [3:0] CmdNop = 4'd0;
  localparam logic [3:0] CmdAdd = 4'd1;
  localparam logic [3:0] CmdSub = 4'd2;
  localparam logic [3:0] CmdShl = 4'd5;
  localparam logic [3:0] CmdShr = 4'd6;

  localparam logic [1:0] RespOk  = 2'd1;
  localparam logic [1:0] RespOvf = 2'd2;
  localparam logic [1:0] RespInv = 2'd3;

  typedef enum logic [0:0] {StIdle, StOp2} state_e;

  typedef struct packed {
    logic [1:0]  resp;
    logic [31:0] data;
    logic [1:0]  tag;
  } entry_t;

  state_e      state_q, state_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [31:0] op1_q, op1_d;
  logic [1:0]  tag_q, tag_d;
  logic        capture;
  logic        dispatch;
  logic        dup;
  logic        op2_skip;

  logic [32:0] sum;
  logic [4:0]  shamt;
  entry_t      exe_ent;
  logic        to_shift;

  logic        add_vld_q [ADD_LAT];
  entry_t      add_ent_q [ADD_LAT];
  logic        sh_vld_q  [SHIFT_LAT];
  entry_t      sh_ent_q  [SHIFT_LAT];
  logic        add_out_vld, sh_out_vld;
  entry_t      add_out_ent, sh_out_ent;

  entry_t          q_q [FIFO_DEPTH];
  entry_t          q_d [FIFO_DEPTH];
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pop;
  entry_t          head;

`ifdef CALC_TAG_CHECK_EN
  logic [3:0] sb_q, sb_d;
  logic       rej_q, rej_d;

  assign dup      = sb_q[req_tag];
  assign op2_skip = rej_q;
  assign tag_err  = capture & dup;
`else
  assign dup      = 1'b0;
  assign op2_skip = 1'b0;
  assign tag_err  = 1'b0;
`endif

  // Request FSM: capture cmd/op1/tag in IDLE, consume op2 in the following cycle.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    op1_d   = op1_q;
    tag_d   = tag_q;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_cmd != CmdNop) begin
          state_d = StOp2;
          capture = 1'b1;
          cmd_d   = req_cmd;
          op1_d   = req_data;
          tag_d   = req_tag;
        end
      end
      StOp2: state_d = StIdle;
    endcase
  end

  // A rejected duplicate still spends its op2 cycle but never reaches a unit.
  assign dispatch = (state_q == StOp2) && !op2_skip;

  // Execute in the op2 cycle; invalid commands ride the add path with resp 3.
  always_comb begin
    sum          = {1'b0, op1_q} + {1'b0, req_data};
    shamt        = req_data[4:0];
    to_shift     = 1'b0;
    exe_ent.resp = RespInv;
    exe_ent.data = '0;
    exe_ent.tag  = tag_q;
    case (cmd_q)
      CmdAdd: begin
        if (sum[32]) begin
          exe_ent.resp = RespOvf;
        end else begin
          exe_ent.resp = RespOk;
          exe_ent.data = sum[31:0];
        end
      end
      CmdSub: begin
        if (op1_q < req_data) begin
          exe_ent.resp = RespOvf;
        end else begin
          exe_ent.resp = RespOk;
          exe_ent.data = op1_q - req_data;
        end
      end
      CmdShl: begin
        to_shift     = 1'b1;
        exe_ent.resp = RespOk;
        exe_ent.data = op1_q << shamt;
      end
      CmdShr: begin
        to_shift     = 1'b1;
        exe_ent.resp = RespOk;
        exe_ent.data = op1_q >> shamt;
      end
      default: ;
    endcase
  end

  // Add/sub delay line; the last stage is the unit output.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < ADD_LAT; i++) begin
        add_vld_q[i] <= 1'b0;
        add_ent_q[i] <= '0;
      end
    end else begin
      add_vld_q[0] <= dispatch && !to_shift;
      add_ent_q[0] <= exe_ent;
      for (int unsigned i = 1; i < ADD_LAT; i++) begin
        add_vld_q[i] <= add_vld_q[i-1];
        add_ent_q[i] <= add_ent_q[i-1];
      end
    end
  end

  // Shift delay line; the last stage is the unit output.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SHIFT_LAT; i++) begin
        sh_vld_q[i] <= 1'b0;
        sh_ent_q[i] <= '0;
      end
    end else begin
      sh_vld_q[0] <= dispatch && to_shift;
      sh_ent_q[0] <= exe_ent;
      for (int unsigned i = 1; i < SHIFT_LAT; i++) begin
        sh_vld_q[i] <= sh_vld_q[i-1];
        sh_ent_q[i] <= sh_ent_q[i-1];
      end
    end
  end

  assign add_out_vld = add_vld_q[ADD_LAT-1];
  assign add_out_ent = add_ent_q[ADD_LAT-1];
  assign sh_out_vld  = sh_vld_q[SHIFT_LAT-1];
  assign sh_out_ent  = sh_ent_q[SHIFT_LAT-1];

  assign pop  = (cnt_q != '0);
  assign head = q_q[0];

  // Compacting queue: pop head first, then push add/sub ahead of shift; full drops.
  always_comb begin
    logic [CntW-1:0] n;
    q_d = q_q;
    n   = cnt_q;
    if (pop) begin
      for (int unsigned i = 0; i + 1 < FIFO_DEPTH; i++) q_d[i] = q_q[i+1];
      q_d[FIFO_DEPTH-1] = '0;
      n = n - CntW'(1);
    end
    if (add_out_vld && (n < DepthC)) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (CntW'(i) == n) q_d[i] = add_out_ent;
      end
      n = n + CntW'(1);
    end
    if (sh_out_vld && (n < DepthC)) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (CntW'(i) == n) q_d[i] = sh_out_ent;
      end
      n = n + CntW'(1);
    end
    cnt_d = n;
  end

`ifdef CALC_TAG_CHECK_EN
  // Outstanding-tag scoreboard: release on report, then mark a fresh capture.
  // With one entry per tag value the queue cannot overflow, so drops never
  // strand a scoreboard bit.
  always_comb begin
    sb_d = sb_q;
    if (pop) sb_d[head.tag] = 1'b0;
    if (capture && !dup) sb_d[req_tag] = 1'b1;
    rej_d = capture && dup;
  end

  // Scoreboard state.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      sb_q  <= '0;
      rej_q <= 1'b0;
    end else begin
      sb_q  <= sb_d;
      rej_q <= rej_d;
    end
  end
`endif

  // FSM, capture registers and response queue.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q <= StIdle;
      cmd_q   <= '0;
      op1_q   <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) q_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      op1_q   <= op1_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
    end
  end

  // Queue head is presented for exactly one cycle, then popped.
  always_comb begin
    out_resp = pop ? head.resp : '0;
    out_data = pop ? head.data : '0;
    out_tag  = pop ? head.tag  : '0;
  end

  // Busy while anything is captured, in flight or queued.
  always_comb begin
    busy = (state_q == StOp2) || pop;
    for (int unsigned i = 0; i < ADD_LAT; i++)   busy = busy | add_vld_q[i];
    for (int unsigned i = 0; i < SHIFT_LAT; i++) busy = busy | sh_vld_q[i];
  end

endmodule
